// File: rtl/analog_probe_scan.sv
// Analog probe scanner: walks the enabled channels in ascending order, takes
// 2**AVG_LOG2 samples per channel from a req/ack backend, and reports the
// average, minimum, maximum and an error flag per channel.
module analog_probe_scan #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 15,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [1:0]        quantity,
  output logic              probe_req,
  output logic [CH_W-1:0]   probe_ch,
  output logic [1:0]        probe_qty,
  input  logic              probe_ack,
  input  logic              probe_ok,
  input  logic [DATA_W-1:0] probe_data,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [DATA_W-1:0] res_avg,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic              res_err,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned SMP_W = AVG_LOG2 + 1;
  localparam logic [SMP_W-1:0] LastSmp = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]       ToLimit = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq,
    StWait,
    StReport,
    StFinish
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0]        remain_q, remain_d;
  logic [1:0]               qty_q, qty_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [7:0]               to_cnt_q, to_cnt_d;
  logic [SMP_W-1:0]         smp_cnt_q, smp_cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] min_q, min_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic                     any_valid_q, any_valid_d;
  logic                     err_q, err_d;
  logic                     res_valid_q, res_valid_d;
  logic [CH_W-1:0]          res_ch_q, res_ch_d;
  logic [DATA_W-1:0]        res_avg_q, res_avg_d;
  logic [DATA_W-1:0]        res_min_q, res_min_d;
  logic [DATA_W-1:0]        res_max_q, res_max_d;
  logic                     res_err_q, res_err_d;

  logic                     start_ok;
  logic                     to_hit;
  logic                     last_smp;
  logic [CH_W-1:0]          pick_ch;
  logic signed [DATA_W-1:0] sample;
  logic signed [ACC_W-1:0]  sample_ext;

  // A start with an illegal quantity or an empty mask only produces a done pulse.
  assign start_ok   = start && (quantity != 2'd3) && (|ch_enable);
  // Counts the current cycle too, so probe_req is high for exactly TIMEOUT cycles.
  assign to_hit     = !probe_ack && ((to_cnt_q + 8'd1) == ToLimit);
  assign last_smp   = (smp_cnt_q == LastSmp);
  assign sample     = probe_data;
  assign sample_ext = ACC_W'(sample);

  // Lowest-index channel still waiting to be scanned.
  always_comb begin
    logic found;
    found   = 1'b0;
    pick_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && remain_q[i]) begin
        pick_ch = CH_W'(i);
        found   = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = start_ok ? StSelect : StFinish;
        end
      end
      StSelect: begin
        state_d = (|remain_q) ? StReq : StFinish;
      end
      StReq, StWait: begin
        if (probe_ack) begin
          // Non-final samples go back through SELECT, giving the one-cycle request gap.
          state_d = last_smp ? StReport : StSelect;
        end else if (to_hit) begin
          state_d = StReport;
        end else begin
          state_d = StWait;
        end
      end
      StReport: state_d = StSelect;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    probe_req = (state_q == StReq) || (state_q == StWait);
    busy      = (state_q != StIdle);
    done      = (state_q == StFinish);
    probe_ch  = ch_q;
    probe_qty = qty_q;
    res_valid = res_valid_q;
    res_ch    = res_ch_q;
    res_avg   = res_avg_q;
    res_min   = res_min_q;
    res_max   = res_max_q;
    res_err   = res_err_q;
  end

  // Datapath next-state: channel bookkeeping, sample accumulation and results.
  always_comb begin
    remain_d    = remain_q;
    qty_d       = qty_q;
    ch_d        = ch_q;
    to_cnt_d    = to_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    acc_d       = acc_q;
    min_d       = min_q;
    max_d       = max_q;
    any_valid_d = any_valid_q;
    err_d       = err_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_avg_d   = res_avg_q;
    res_min_d   = res_min_q;
    res_max_d   = res_max_q;
    res_err_d   = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          remain_d = ch_enable;
          qty_d    = quantity;
        end
      end
      StSelect: begin
        if (|remain_q) begin
          ch_d     = pick_ch;
          to_cnt_d = '0;
        end
      end
      StReq, StWait: begin
        if (probe_ack) begin
          smp_cnt_d = smp_cnt_q + 1'b1;
          to_cnt_d  = '0;
          if (probe_ok) begin
            acc_d       = acc_q + sample_ext;
            any_valid_d = 1'b1;
            if (!any_valid_q || (sample < min_q)) begin
              min_d = sample;
            end
            if (!any_valid_q || (sample > max_q)) begin
              max_d = sample;
            end
          end else begin
            // Invalid samples still count towards the sample total.
            err_d = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_hit) begin
            err_d = 1'b1;
          end
        end
      end
      StReport: begin
        res_valid_d = 1'b1;
        res_ch_d    = ch_q;
        res_err_d   = err_q || !any_valid_q;
        if (any_valid_q) begin
          // Arithmetic shift floors toward -inf.
          res_avg_d = DATA_W'(acc_q >>> AVG_LOG2);
          res_min_d = min_q;
          res_max_d = max_q;
        end else begin
          res_avg_d = '0;
          res_min_d = '0;
          res_max_d = '0;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (ch_q == CH_W'(i)) begin
            remain_d[i] = 1'b0;
          end
        end
        smp_cnt_d   = '0;
        to_cnt_d    = '0;
        acc_d       = '0;
        min_d       = '0;
        max_d       = '0;
        any_valid_d = 1'b0;
        err_d       = 1'b0;
      end
      StFinish: ;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remain_q    <= '0;
      qty_q       <= '0;
      ch_q        <= '0;
      to_cnt_q    <= '0;
      smp_cnt_q   <= '0;
      acc_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      any_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_avg_q   <= '0;
      res_min_q   <= '0;
      res_max_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      remain_q    <= remain_d;
      qty_q       <= qty_d;
      ch_q        <= ch_d;
      to_cnt_q    <= to_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      acc_q       <= acc_d;
      min_q       <= min_d;
      max_q       <= max_d;
      any_valid_q <= any_valid_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_avg_q   <= res_avg_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_analog_probe_scan.sv
// Scoreboard bench for analog_probe_scan: stimulus pushes expected results,
// a monitor pops and compares on res_valid/done, and a backend model serves
// probe requests from a response queue.
module tb_analog_probe_scan;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 32;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ch_enable = '0;
  logic [1:0]  quantity = '0;
  logic        probe_req;
  logic [1:0]  probe_ch;
  logic [1:0]  probe_qty;
  logic        probe_ack = 1'b0;
  logic        probe_ok = 1'b0;
  logic [31:0] probe_data = '0;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [31:0] res_avg;
  logic [31:0] res_min;
  logic [31:0] res_max;
  logic        res_err;
  logic        busy;
  logic        done;

  analog_probe_scan #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .ch_enable (ch_enable),
    .quantity  (quantity),
    .probe_req (probe_req),
    .probe_ch  (probe_ch),
    .probe_qty (probe_qty),
    .probe_ack (probe_ack),
    .probe_ok  (probe_ok),
    .probe_data(probe_data),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_avg   (res_avg),
    .res_min   (res_min),
    .res_max   (res_max),
    .res_err   (res_err),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int ch;
    int avg;
    int mn;
    int mx;
    bit err;
  } exp_t;

  typedef struct {
    int delay;
    bit noack;
    bit ok;
    int data;
    int ch;
    int qty;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  bit   spur_en = 1'b0;

  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic push_res(input int ch, input int avg, input int mn, input int mx, input bit err);
    exp_t e;
    e.is_done = 1'b0;
    e.ch = ch;
    e.avg = avg;
    e.mn = mn;
    e.mx = mx;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.ch = 0;
    e.avg = 0;
    e.mn = 0;
    e.mx = 0;
    e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_rsp(input int delay, input bit noack, input bit ok, input int data,
                          input int ch, input int qty);
    rsp_t r;
    r.delay = delay;
    r.noack = noack;
    r.ok = ok;
    r.data = data;
    r.ch = ch;
    r.qty = qty;
    rsp_q.push_back(r);
  endtask

  // Caller is at a negedge; start is high across exactly one rising edge.
  task automatic start_scan(input logic [3:0] mask, input logic [1:0] qty);
    start = 1'b1;
    ch_enable = mask;
    quantity = qty;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int seen0;
    int n;
    seen0 = done_seen;
    n = 0;
    while (done_seen == seen0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", longint'(done_seen != seen0), 1);
  endtask

  // Monitor: compare every presented result or done against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got ch %0d avg %0d expected nothing", res_ch,
                 $signed(res_avg));
      end else begin
        e = exp_q.pop_front();
        if (e.is_done) begin
          total++;
          bad++;
          $display("FAIL result_order: got result ch %0d expected done", res_ch);
        end else begin
          check("res_ch", res_ch, e.ch);
          check("res_avg", $signed(res_avg), e.avg);
          check("res_min", $signed(res_min), e.mn);
          check("res_max", $signed(res_max), e.mx);
          check("res_err", res_err, e.err);
        end
      end
    end
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done expected nothing");
      end else begin
        e = exp_q.pop_front();
        if (!e.is_done) begin
          total++;
          bad++;
          $display("FAIL done_order: got done expected result ch %0d", e.ch);
        end else begin
          check("done_busy", busy, 1);
        end
      end
    end
  end

  // Backend model: serves each request from rsp_q, optionally with a spurious
  // ack in the gap cycle that follows every real ack.
  bit   be_active = 1'b0;
  bit   spur_pend = 1'b0;
  int   be_wait = 0;
  int   be_hi = 0;
  rsp_t be_cur;

  always @(negedge clk) begin
    probe_ack = 1'b0;
    probe_ok = 1'b0;
    if (!probe_req) begin
      if (be_active) begin
        if (be_cur.noack) check("timeout_req_cycles", be_hi, TIMEOUT);
        be_active = 1'b0;
      end
      if (spur_pend) begin
        probe_ack = 1'b1;
        probe_ok = 1'b1;
        probe_data = 32'd12345;
        spur_pend = 1'b0;
      end
    end else begin
      if (!be_active) begin
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_probe_req: got ch %0d qty %0d expected no request",
                   probe_ch, probe_qty);
          be_cur.delay = 0;
          be_cur.noack = 1'b1;
          be_cur.ok = 1'b0;
          be_cur.data = 0;
          be_cur.ch = 0;
          be_cur.qty = 0;
        end else begin
          be_cur = rsp_q.pop_front();
          check("probe_ch", probe_ch, be_cur.ch);
          check("probe_qty", probe_qty, be_cur.qty);
        end
        be_active = 1'b1;
        be_wait = be_cur.delay;
        be_hi = 0;
      end
      be_hi++;
      if (!be_cur.noack && be_wait == 0) begin
        probe_ack = 1'b1;
        probe_ok = be_cur.ok;
        probe_data = be_cur.data;
        be_active = 1'b0;
        if (spur_en) spur_pend = 1'b1;
      end else if (be_wait > 0) begin
        be_wait--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_probe_req", probe_req, 0);
    check("rst_probe_ch", probe_ch, 0);
    check("rst_probe_qty", probe_qty, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_avg", res_avg, 0);
    check("rst_res_err", res_err, 0);
    reset_n = 1'b1;

    // Two channels, four samples each, varied ack delays; start on first edge out of reset.
    push_rsp(0, 0, 1, 10, 0, 0);
    push_rsp(2, 0, 1, 20, 0, 0);
    push_rsp(1, 0, 1, 30, 0, 0);
    push_rsp(0, 0, 1, 40, 0, 0);
    push_rsp(3, 0, 1, -4, 2, 0);
    push_rsp(0, 0, 1, -4, 2, 0);
    push_rsp(0, 0, 1, -4, 2, 0);
    push_rsp(1, 0, 1, -5, 2, 0);
    push_res(0, 25, 10, 40, 0);
    push_res(2, -5, -5, -4, 0);
    push_done();
    start_scan(4'b0101, 2'd0);
    check("busy_after_start", busy, 1);
    wait_done();
    repeat (2) @(negedge clk);

    // Timeout on ch0, scan continues with ch1.
    push_rsp(0, 1, 0, 0, 0, 1);
    push_rsp(0, 0, 1, 1, 1, 1);
    push_rsp(0, 0, 1, 2, 1, 1);
    push_rsp(0, 0, 1, 3, 1, 1);
    push_rsp(0, 0, 1, 4, 1, 1);
    push_res(0, 0, 0, 0, 1);
    push_res(1, 2, 1, 4, 0);
    push_done();
    start_scan(4'b0011, 2'd1);
    wait_done();
    repeat (2) @(negedge clk);

    // Invalid second sample: still counted, divided by four.
    push_rsp(0, 0, 1, 8, 3, 2);
    push_rsp(1, 0, 0, 99, 3, 2);
    push_rsp(0, 0, 1, 8, 3, 2);
    push_rsp(2, 0, 1, 8, 3, 2);
    push_res(3, 6, 8, 8, 1);
    push_done();
    start_scan(4'b1000, 2'd2);
    wait_done();
    repeat (2) @(negedge clk);

    // Illegal quantity: done next cycle, busy one cycle, start in FINISH ignored.
    push_done();
    start_scan(4'b1111, 2'd3);
    check("illegal_qty_busy", busy, 1);
    check("illegal_qty_done", done, 1);
    start = 1'b1;
    ch_enable = 4'b1111;
    quantity = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check("finish_start_ignored_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("finish_start_ignored_idle", busy, 0);

    // Empty mask behaves the same way.
    push_done();
    start_scan(4'b0000, 2'd0);
    check("empty_mask_done", done, 1);
    @(negedge clk);
    check("empty_mask_idle", busy, 0);
    repeat (2) @(negedge clk);

    // Start while busy and acks while probe_req is low are both ignored.
    spur_en = 1'b1;
    push_rsp(1, 0, 1, 100, 2, 0);
    push_rsp(0, 0, 1, -100, 2, 0);
    push_rsp(2, 0, 1, 7, 2, 0);
    push_rsp(0, 0, 1, -3, 2, 0);
    push_res(2, 1, -100, 100, 0);
    push_done();
    start_scan(4'b0100, 2'd0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    ch_enable = 4'b1011;
    quantity = 2'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    spur_en = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_busy_start", busy, 0);
    check("res_hold_avg", $signed(res_avg), 1);

    // Reset while waiting for an ack aborts the scan silently.
    push_rsp(8, 0, 1, 55, 0, 1);
    start_scan(4'b0001, 2'd1);
    n = 0;
    while (!probe_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("probe_req_seen_before_reset", probe_req, 1);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("reset_drops_probe_req", probe_req, 0);
    check("reset_clears_busy", busy, 0);
    check("reset_clears_res_avg", res_avg, 0);
    repeat (2) @(negedge clk);
    push_rsp(0, 0, 1, 5, 1, 1);
    push_rsp(1, 0, 1, 6, 1, 1);
    push_rsp(0, 0, 1, 7, 1, 1);
    push_rsp(0, 0, 1, 8, 1, 1);
    push_rsp(0, 0, 1, -1, 2, 1);
    push_rsp(2, 0, 1, -2, 2, 1);
    push_rsp(0, 0, 1, -3, 2, 1);
    push_rsp(0, 0, 1, -4, 2, 1);
    push_res(1, 6, 5, 8, 0);
    push_res(2, -3, -4, -1, 0);
    push_done();
    reset_n = 1'b1;
    start_scan(4'b0110, 2'd1);
    wait_done();

    repeat (5) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    check("rsp_queue_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
